multi_cycle_adder: RTL and testbench
====================================

// Module: multi_cycle_adder
// PURPOSE
//  Parametrised, sequential N-bit adder/subtractor. Builds the 1-bit half/full-adder primitive
//  out to WIDTH bits and processes DIGIT bits per clock with a registered inter-digit carry.
//  Trades latency for area inside the ALU datapath.
//  Uses a START/BUSY/DONE handshake toward the control unit.
//  Reports sum, carry-out, signed overflow and zero flags.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  DIGIT   4  bits processed per clock; WIDTH % DIGIT must be 0 (elaboration error otherwise)
//  Derived: NDIG = WIDTH/DIGIT = number of RUN cycles
// PORTS
//  CLK    in   1      clock; all state changes on rising edge
//  RST    in   1      reset, synchronous, active-low
//  START  in   1      request; sampled only in IDLE or DONE state
//  MODE   in   1      0 = add (A+B), 1 = subtract (A-B); sampled with START
//  A      in   WIDTH  operand A; sampled with START
//  B      in   WIDTH  operand B; sampled with START
//  Y      out  WIDTH  result; registered
//  CO     out  1      carry-out; for subtract, 1 = no borrow (A >= B unsigned)
//  V      out  1      signed overflow = carry into MSB XOR carry out of MSB
//  ZERO   out  1      1 when Y == 0
//  BUSY   out  1      1 while state == RUN
//  DONE   out  1      1-cycle pulse while state == DONE
// BEHAVIOUR
//  Reset: RST==0 at an edge -> state IDLE; Y=0, CO=0, V=0, ZERO=0, BUSY=0, DONE=0.
//   Digit counter and carry register are cleared.
//  States: IDLE, RUN, DONE.
//   IDLE -START-> RUN
//   RUN --(digit NDIG-1 done)--> DONE
//   DONE -START-> RUN; DONE -no START-> IDLE
//  Accept (START=1 in IDLE/DONE):
//   Latch A, and B XOR {WIDTH{MODE}}.
//   Carry register <= MODE (two's-complement subtract).
//   Digit counter <= 0.
//  RUN edge k (k = 0..NDIG-1):
//   Compute bits [k*DIGIT +: DIGIT] with a DIGIT-bit ripple adder plus the carry register.
//   Store the digit into the result shift/accumulate register.
//   Carry register <= digit carry-out.
//   On the MSB digit, also capture carry into bit WIDTH-1.
//  Completion (edge k = NDIG-1): Y, CO, V, ZERO all update at this edge; next state = DONE.
//  Latency: START sampled at edge t0 -> DONE high in the cycle after edge t0+NDIG.
//   Back-to-back throughput: one result per NDIG+1 cycles.
//  Y/CO/V/ZERO hold the previous result throughout RUN. They change only at completion or reset.
//  START in RUN is ignored; the operation in flight is not disturbed. A/B/MODE changes in RUN are ignored.
//  START in DONE is accepted: DONE stays a single pulse and BUSY rises next cycle.
//  Reset mid-RUN aborts: no DONE pulse; outputs take reset values.
//  Arithmetic is modulo 2^WIDTH; no saturation.
//  NDIG == 1 (DIGIT == WIDTH) is legal and gives a single RUN cycle.
// TESTING (defaults WIDTH=32, DIGIT=4 unless stated; DONE checked exactly 9 cycles after START edge)
//  Add 5+3 -> Y=0x00000008, CO=0, V=0, ZERO=0; BUSY high 8 cycles; DONE 1 cycle.
//  Add 0xFFFFFFFF+1 -> Y=0, CO=1, V=0, ZERO=1.
//  Add 0x7FFFFFFF+1 -> Y=0x80000000, CO=0, V=1.
//  Sub 5-7 -> Y=0xFFFFFFFE, CO=0, V=0.
//  Sub 0x80000000-1 -> Y=0x7FFFFFFF, CO=1, V=1.
//  Handshake:
//   START pulsed again at RUN cycle 2 with new operands -> ignored, first result intact.
//   START held in DONE cycle -> second op runs, DONE again 9 cycles later.
//  RST=0 during RUN cycle 3 -> next cycle BUSY=0, Y=0, flags 0, no DONE.
//   Fresh START after reset still gives correct results.
//  Rebuild with DIGIT=1 (32 RUN cycles) and DIGIT=32 (1 RUN cycle).
//   Random add/sub vectors vs. behavioural model; latency = NDIG+1.

Source files
------------

// File: rtl/multi_cycle_adder.sv
// Sequential WIDTH-bit adder/subtractor: DIGIT bits per clock through a ripple of
// half/full-adder cells, with a registered carry between digits and START/BUSY/DONE handshake.

module mca_half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module mca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  mca_half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  mca_half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// One digit of ripple carry; c[i] is the carry into bit i, c[DIGIT] the digit carry-out.
module mca_ripple_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic [DIGIT:0]   c
);
  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    mca_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end
endmodule

module multi_cycle_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             V,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("multi_cycle_adder: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
  logic             carry;
  logic [CW-1:0]    dig;
  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic [DIGIT:0]   c_dig;
  logic             last;

  assign a_dig = opa[int'(dig)*DIGIT +: DIGIT];
  assign b_dig = opb[int'(dig)*DIGIT +: DIGIT];
  assign last  = (int'(dig) == NDIG - 1);

  mca_ripple_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (a_dig),
    .b  (b_dig),
    .ci (carry),
    .s  (s_dig),
    .c  (c_dig)
  );

  // Accumulator with the current digit merged in; on the last digit this is the full result.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[int'(dig)*DIGIT +: DIGIT] = s_dig;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= S_IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      dig   <= '0;
      Y     <= '0;
      CO    <= 1'b0;
      V     <= 1'b0;
      ZERO  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          DONE <= 1'b0;
          if (START) begin
            // Subtract as A + ~B + 1: invert B here, seed the carry with MODE.
            opa   <= A;
            opb   <= B ^ {WIDTH{MODE}};
            carry <= MODE;
            dig   <= '0;
            BUSY  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc   <= acc_nxt;
          carry <= c_dig[DIGIT];
          dig   <= dig + CW'(1);
          if (last) begin
            Y     <= acc_nxt;
            CO    <= c_dig[DIGIT];
            V     <= c_dig[DIGIT] ^ c_dig[DIGIT-1];
            ZERO  <= (acc_nxt == '0);
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_adder.sv
// Bench for multi_cycle_adder: DIGIT=4, 1 and 32 builds share one stimulus stream and
// are each checked every cycle against an arithmetic model of the handshake and result.

module tb_multi_cycle_adder;
  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] y [3];
  logic         co [3], v [3], zero [3], busy [3], done [3];

  always #5 clk = ~clk;

  multi_cycle_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .CLK(clk), .RST(rst), .START(start), .MODE(mode), .A(a), .B(b),
    .Y(y[0]), .CO(co[0]), .V(v[0]), .ZERO(zero[0]), .BUSY(busy[0]), .DONE(done[0]));
  multi_cycle_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .CLK(clk), .RST(rst), .START(start), .MODE(mode), .A(a), .B(b),
    .Y(y[1]), .CO(co[1]), .V(v[1]), .ZERO(zero[1]), .BUSY(busy[1]), .DONE(done[1]));
  multi_cycle_adder #(.WIDTH(W), .DIGIT(32)) u_d32 (
    .CLK(clk), .RST(rst), .START(start), .MODE(mode), .A(a), .B(b),
    .Y(y[2]), .CO(co[2]), .V(v[2]), .ZERO(zero[2]), .BUSY(busy[2]), .DONE(done[2]));

  int n_cmp = 0, n_bad = 0;
  bit started = 1'b0;

  function automatic int ndig_of(int i);
    return (i == 0) ? 8 : ((i == 1) ? 32 : 1);
  endfunction

  // Returns {co, v, zero, y} straight from the arithmetic definition.
  function automatic logic [W+2:0] ref_calc(logic [W-1:0] x, logic [W-1:0] z, logic m);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         ovf;
    s   = m ? ({1'b0, x} + {1'b0, ~z} + 33'd1) : ({1'b0, x} + {1'b0, z});
    r   = s[W-1:0];
    ovf = m ? ((x[W-1] != z[W-1]) && (r[W-1] != x[W-1]))
            : ((x[W-1] == z[W-1]) && (r[W-1] != x[W-1]));
    return {s[W], ovf, (r == '0), r};
  endfunction

  // Model: phase 0 idle, 1 running (rem edges left), 2 done pulse.
  int           phase [3], rem [3];
  logic [W-1:0] ea [3], eb [3], ey [3];
  logic         em [3], eco [3], ev [3], ez [3], ebusy [3], edone [3];

  always @(posedge clk) begin
    started <= 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        phase[i] <= 0;   ey[i] <= '0;  eco[i] <= 1'b0; ev[i] <= 1'b0;
        ez[i] <= 1'b0;   ebusy[i] <= 1'b0; edone[i] <= 1'b0;
      end else if (phase[i] == 1) begin
        rem[i] <= rem[i] - 1;
        if (rem[i] == 1) begin
          {eco[i], ev[i], ez[i], ey[i]} <= ref_calc(ea[i], eb[i], em[i]);
          phase[i] <= 2; ebusy[i] <= 1'b0; edone[i] <= 1'b1;
        end
      end else begin
        edone[i] <= 1'b0;
        if (start) begin
          ea[i] <= a; eb[i] <= b; em[i] <= mode; rem[i] <= ndig_of(i);
          phase[i] <= 1; ebusy[i] <= 1'b1;
        end else begin
          phase[i] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (y[i] !== ey[i] || co[i] !== eco[i] || v[i] !== ev[i] || zero[i] !== ez[i] ||
            busy[i] !== ebusy[i] || done[i] !== edone[i]) begin
          n_bad++;
          $display("FAIL cycle_d%0d @%0t: got y=%h co=%b v=%b z=%b busy=%b done=%b, need y=%h co=%b v=%b z=%b busy=%b done=%b",
                   ndig_of(i), $time, y[i], co[i], v[i], zero[i], busy[i], done[i],
                   ey[i], eco[i], ev[i], ez[i], ebusy[i], edone[i]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, need %h", nm, got, exp);
    end
  endtask

  // Issue one op; returns edges from the START edge to DONE visible on the DIGIT=4 build.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] z, input logic m,
                        output int lat, output int busy_cyc);
    @(negedge clk); start = 1'b1; a = x; b = z; mode = m;
    @(negedge clk); start = 1'b0;
    lat = 0; busy_cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (busy[0]) busy_cyc++;
      if (done[0]) begin lat = k; break; end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (phase[0] == 0 && phase[1] == 0 && phase[2] == 0) return;
    end
    chk("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  int lat, bc;

  initial begin
    // Model pinned to hand-computed values.
    chk("ref_add_5_3",    64'(ref_calc(32'd5, 32'd3, 1'b0)),                      {29'd0, 3'b000, 32'h0000_0008});
    chk("ref_add_wrap",   64'(ref_calc(32'hFFFF_FFFF, 32'd1, 1'b0)),              {29'd0, 3'b101, 32'h0000_0000});
    chk("ref_add_ovf",    64'(ref_calc(32'h7FFF_FFFF, 32'd1, 1'b0)),              {29'd0, 3'b010, 32'h8000_0000});
    chk("ref_sub_5_7",    64'(ref_calc(32'd5, 32'd7, 1'b1)),                      {29'd0, 3'b000, 32'hFFFF_FFFE});
    chk("ref_sub_ovf",    64'(ref_calc(32'h8000_0000, 32'd1, 1'b1)),              {29'd0, 3'b110, 32'h7FFF_FFFF});

    repeat (3) @(negedge clk);
    #1;
    chk("reset_y",     64'(y[0]), 64'd0);
    chk("reset_flags", 64'({co[0], v[0], zero[0], busy[0], done[0]}), 64'd0);
    rst = 1'b1;

    run_op(32'd5, 32'd3, 1'b0, lat, bc);
    chk("add53_lat", 64'(lat), 64'd9);
    chk("add53_busy_cycles", 64'(bc), 64'd8);
    chk("add53_y", 64'({co[0], v[0], zero[0], y[0]}), {29'd0, 3'b000, 32'h8});
    @(negedge clk); #1;
    chk("add53_done_pulse", 64'(done[0]), 64'd0);
    wait_idle();

    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, bc);
    chk("addwrap_y", 64'({co[0], v[0], zero[0], y[0]}), {29'd0, 3'b101, 32'h0});
    wait_idle();
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, lat, bc);
    chk("addovf_y", 64'({co[0], v[0], zero[0], y[0]}), {29'd0, 3'b010, 32'h8000_0000});
    wait_idle();
    run_op(32'd5, 32'd7, 1'b1, lat, bc);
    chk("sub57_y", 64'({co[0], v[0], zero[0], y[0]}), {29'd0, 3'b000, 32'hFFFF_FFFE});
    wait_idle();
    run_op(32'h8000_0000, 32'd1, 1'b1, lat, bc);
    chk("subovf_y", 64'({co[0], v[0], zero[0], y[0]}), {29'd0, 3'b110, 32'h7FFF_FFFF});
    wait_idle();

    // START again at RUN cycle 2 with new operands: must not disturb the op in flight.
    @(negedge clk); start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; mode = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    for (int k = 3; k <= 20; k++) begin
      if (k > 3) @(negedge clk);
      #1;
      if (done[0]) begin lat = k; break; end
    end
    chk("ignore_lat", 64'(lat), 64'd9);
    chk("ignore_y", 64'(y[0]), 64'h2345_6789);
    wait_idle();

    // START held through the DONE cycle: second op runs back to back.
    run_op(32'd40, 32'd2, 1'b0, lat, bc);
    chk("b2b_first_y", 64'(y[0]), 64'd42);
    start = 1'b1; a = 32'd100; b = 32'd1; mode = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (done[0]) begin lat = k; break; end
    end
    chk("b2b_lat", 64'(lat), 64'd9);
    chk("b2b_y", 64'({co[0], y[0]}), {31'd0, 1'b1, 32'd99});
    wait_idle();

    // Reset during RUN cycle 3 aborts the op.
    @(negedge clk); start = 1'b1; a = 32'd9; b = 32'd9; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("abort_outputs", 64'({co[0], v[0], zero[0], busy[0], done[0], y[0]}), 64'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (done[0] || done[1] || done[2]) chk("abort_no_done", 64'd1, 64'd0);
    end
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, lat, bc);
    chk("after_abort_y", 64'({co[0], v[0], zero[0], y[0]}), {29'd0, 3'b010, 32'h8000_0000});
    wait_idle();

    // Random traffic, including START during RUN/DONE and occasional resets.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a     = rnd_op();
      b     = rnd_op();
      mode  = $urandom_range(0, 1) == 1;
      rst   = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk); start = 1'b0; rst = 1'b1;
    wait_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
